layer_sequencer: RTL

Layer-level scheduler for the neural accelerator datapath. It walks a program of layer descriptors held in instruction RAM and, for each layer, configures the address generator's base addresses. It then launches the address generator and MAC core, waits for completion, and advances to the next layer. Neuron storage is ping-ponged between two regions of the neuron RAM, so each layer's outputs become the next layer's inputs.

---
 rtl/layer_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : layer_sequencer
// Description : Layer-level scheduler for the neural accelerator datapath.
//               Walks layer descriptors in instruction RAM, programs the
//               neuron/weight base addresses and launches the address
//               generator and MAC core once per layer. Neuron storage
//               ping-pongs between two buffers from layer to layer.
//               Optional feature macro: LAYER_SEQ_PERF_EN adds a
//               saturating 16-bit count of cycles spent in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int BUF_B_BASE = 128,
    parameter int MAX_LAYERS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [15:0]       instr_data,
    output logic              ag_start,
    output logic              mac_rst,
    input  logic              ag_done,
    output logic [ADDR_W-1:0] neuro_read_base,
    output logic [ADDR_W-1:0] neuro_write_base,
    output logic [ADDR_W-1:0] weight_read_base,
    output logic [ADDR_W-1:0] layer_idx,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef LAYER_SEQ_PERF_EN
    ,
    output logic [15:0]       perf_cycles
`endif
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_fetch   = 3'd1;
    localparam logic [2:0] c_st_decode  = 3'd2;
    localparam logic [2:0] c_st_launch  = 3'd3;
    localparam logic [2:0] c_st_run     = 3'd4;
    localparam logic [2:0] c_st_advance = 3'd5;
    localparam logic [2:0] c_st_done    = 3'd6;

    localparam logic [ADDR_W-1:0] c_buf_b_base = ADDR_W'(BUF_B_BASE);
    // One extra bit so a guard equal to 2^ADDR_W is still reachable.
    localparam logic [ADDR_W:0]   c_max_layers = (ADDR_W+1)'(MAX_LAYERS);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_ip;
    logic [ADDR_W-1:0] r_rd_base;
    logic [ADDR_W-1:0] r_wr_base;
    logic [ADDR_W-1:0] r_wt_base;
    logic [7:0]        r_n_in;
    logic [7:0]        r_n_out;
    logic              r_err;

    logic [15:0]       w_prod;
    logic [ADDR_W:0]   w_ip_inc;

    // Weight footprint of the current layer and the next instruction pointer.
    assign w_prod   = 16'(r_n_in) * 16'(r_n_out);
    assign w_ip_inc = {1'b0, r_ip} + (ADDR_W+1)'(1);

    // Main sequencer: state, instruction pointer, base addresses, error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_ip      <= '0;
            r_rd_base <= '0;
            r_wr_base <= '0;
            r_wt_base <= '0;
            r_n_in    <= '0;
            r_n_out   <= '0;
            r_err     <= 1'b0;
        end else if (abort) begin
            // Abort wins over start and ag_done; bases and index hold.
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_ip      <= '0;
                        r_err     <= 1'b0;
                        r_rd_base <= '0;
                        r_wr_base <= c_buf_b_base;
                        r_wt_base <= '0;
                        r_state   <= c_st_fetch;
                    end
                end
                c_st_fetch: begin
                    r_n_in  <= instr_data[15:8];
                    r_n_out <= instr_data[7:0];
                    r_state <= c_st_decode;
                end
                c_st_decode: begin
                    if (r_n_out == 8'd0) begin
                        r_state <= c_st_done;
                    end else if (r_n_in == 8'd0) begin
                        r_err   <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_state <= c_st_launch;
                    end
                end
                c_st_launch: begin
                    r_state <= c_st_run;
                end
                c_st_run: begin
                    if (ag_done) begin
                        r_state <= c_st_advance;
                    end
                end
                c_st_advance: begin
                    // Weight base wraps modulo 2^ADDR_W by design.
                    r_wt_base <= r_wt_base + ADDR_W'(w_prod);
                    r_rd_base <= r_wr_base;
                    r_wr_base <= r_rd_base;
                    r_ip      <= w_ip_inc[ADDR_W-1:0];
                    if (w_ip_inc == c_max_layers) begin
                        r_err   <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_state <= c_st_fetch;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef LAYER_SEQ_PERF_EN
    logic [15:0] r_perf_cycles;

    // Saturating count of RUN cycles, cleared when a program is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_cycles <= '0;
        end else if (r_state == c_st_idle && start && !abort) begin
            r_perf_cycles <= '0;
        end else if (r_state == c_st_run && r_perf_cycles != 16'hFFFF) begin
            r_perf_cycles <= r_perf_cycles + 16'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

    // All outputs are registers or decodes of the registered state.
    assign instr_addr       = r_ip;
    assign layer_idx        = r_ip;
    assign neuro_read_base  = r_rd_base;
    assign neuro_write_base = r_wr_base;
    assign weight_read_base = r_wt_base;
    assign ag_start         = (r_state == c_st_launch);
    assign mac_rst          = (r_state == c_st_launch);
    assign busy             = (r_state != c_st_idle);
    assign done             = (r_state == c_st_done);
    assign err              = r_err;

endmodule
`default_nettype wire
